// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcodes, FSM states and op classification for ula_multiciclo
// Defining ULA_DIV_EN makes DIV/DIVU multicycle ops; otherwise they decode as illegal.
package ula_pkg;

  localparam logic [4:0] OP_SLL   = 5'd0;
  localparam logic [4:0] OP_SRL   = 5'd1;
  localparam logic [4:0] OP_SRA   = 5'd2;
  localparam logic [4:0] OP_SLLV  = 5'd3;
  localparam logic [4:0] OP_SRLV  = 5'd4;
  localparam logic [4:0] OP_SRAV  = 5'd5;
  localparam logic [4:0] OP_ADD   = 5'd6;
  localparam logic [4:0] OP_SUB   = 5'd7;
  localparam logic [4:0] OP_AND   = 5'd8;
  localparam logic [4:0] OP_OR    = 5'd9;
  localparam logic [4:0] OP_XOR   = 5'd10;
  localparam logic [4:0] OP_NOR   = 5'd11;
  localparam logic [4:0] OP_SLT   = 5'd12;
  localparam logic [4:0] OP_SLTU  = 5'd13;
  localparam logic [4:0] OP_LUI   = 5'd14;
  localparam logic [4:0] OP_ORI   = 5'd15;
  localparam logic [4:0] OP_MULT  = 5'd16;
  localparam logic [4:0] OP_MULTU = 5'd17;
  localparam logic [4:0] OP_DIV   = 5'd18;
  localparam logic [4:0] OP_DIVU  = 5'd19;
  localparam logic [4:0] OP_MFHI  = 5'd20;
  localparam logic [4:0] OP_MFLO  = 5'd21;
  localparam logic [4:0] OP_MTHI  = 5'd22;
  localparam logic [4:0] OP_MTLO  = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
`ifdef ULA_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/ula_mul_div_core.sv
// rtl/ula_mul_div_core.sv - iterative shift-add multiplier / restoring divider on magnitudes
// ULA_DIV_EN adds the divide step, the div port and div0 detection.
module ula_mul_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sgn,
`ifdef ULA_DIV_EN
  input  logic             div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   hi_r, lo_r, b_r, a_mag, b_mag;
  logic [CW-1:0]      cnt;
  logic               neg_q;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

  assign a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (sgn && b[WIDTH-1]) ? -b : b;
  assign mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : '0);
  assign prod    = {hi_r, lo_r};
  assign last    = (cnt == CW'(WIDTH - 1));

`ifdef ULA_DIV_EN
  logic           div_r, neg_r, zero_r;
  logic [WIDTH:0] div_sh, div_diff;

  // A zero divisor never borrows, so the quotient fills with ones and the
  // remainder ends up holding |dividend|; the sign fix then restores In1.
  assign div_sh   = {hi_r, lo_r[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, b_r};
  assign div0     = div_r && zero_r;

  always_comb begin
    if (div_r) begin
      lo_out = neg_q ? -lo_r : lo_r;
      hi_out = neg_r ? -hi_r : hi_r;
    end else begin
      {hi_out, lo_out} = neg_q ? -prod : prod;
    end
  end
`else
  assign div0 = 1'b0;
  assign {hi_out, lo_out} = neg_q ? -prod : prod;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hi_r  <= '0;
      lo_r  <= '0;
      b_r   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
`ifdef ULA_DIV_EN
      div_r  <= 1'b0;
      neg_r  <= 1'b0;
      zero_r <= 1'b0;
`endif
    end else if (load) begin
      hi_r  <= '0;
      lo_r  <= a_mag;
      b_r   <= b_mag;
      cnt   <= '0;
      neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]) && (b != '0);
`ifdef ULA_DIV_EN
      div_r  <= div;
      neg_r  <= sgn && a[WIDTH-1];
      zero_r <= (b == '0);
`endif
    end else if (step) begin
      cnt <= cnt + CW'(1);
`ifdef ULA_DIV_EN
      if (div_r) begin
        if (!div_diff[WIDTH]) begin
          hi_r <= div_diff[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_r <= div_sh[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b0};
        end
      end else
`endif
      begin
        hi_r <= mul_sum[WIDTH:1];
        lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multicycle ALU: start/done handshake, base ops, HI/LO, mul/div engine
// ULA_DIV_EN enables DIV/DIVU; without it OP 18/19 complete in one cycle as illegal.
module ula_multiciclo import ula_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       OP,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [4:0]       shamt,
  input  logic [IMM_W-1:0] immediate,
  input  logic             bne,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Zero_flag,
  output logic             div0,
  output logic             illegal_op
);

  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] hi, lo, base_res, core_hi, core_lo;
  logic             bne_q, base_ill, multi, core_last, core_div0;
  logic [SW-1:0]    fixed_sh, var_sh;

  assign multi     = is_multicycle(OP);
  assign fixed_sh  = SW'(shamt);
  assign var_sh    = In1[SW-1:0];
  assign Zero_flag = bne_q ? (result != '0) : (result == '0);

  always_comb begin
    base_res = '0;
    base_ill = 1'b0;
    case (OP)
      OP_SLL:  base_res = In2 << fixed_sh;
      OP_SRL:  base_res = In2 >> fixed_sh;
      OP_SRA:  base_res = $signed(In2) >>> fixed_sh;
      OP_SLLV: base_res = In2 << var_sh;
      OP_SRLV: base_res = In2 >> var_sh;
      OP_SRAV: base_res = $signed(In2) >>> var_sh;
      OP_ADD:  base_res = In1 + In2;
      OP_SUB:  base_res = In1 - In2;
      OP_AND:  base_res = In1 & In2;
      OP_OR:   base_res = In1 | In2;
      OP_XOR:  base_res = In1 ^ In2;
      OP_NOR:  base_res = ~(In1 | In2);
      OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, $signed(In1) < $signed(In2)};
      OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, In1 < In2};
      OP_LUI:  base_res = {immediate, {(WIDTH-IMM_W){1'b0}}};
      OP_ORI:  base_res = In1 | {{(WIDTH-IMM_W){1'b0}}, immediate};
      OP_MFHI: base_res = hi;
      OP_MFLO: base_res = lo;
      OP_MTHI, OP_MTLO: base_res = In1;
      // Only reached as a one-cycle op when the divider is not built.
      OP_DIV, OP_DIVU: base_ill = 1'b1;
      default: base_ill = 1'b1;
    endcase
  end

  ula_mul_div_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .load   (start && (state == ST_IDLE) && multi),
    .step   (state == ST_RUN),
    .sgn    ((OP == OP_MULT) || (OP == OP_DIV)),
`ifdef ULA_DIV_EN
    .div    ((OP == OP_DIV) || (OP == OP_DIVU)),
`endif
    .a      (In1),
    .b      (In2),
    .last   (core_last),
    .hi_out (core_hi),
    .lo_out (core_lo),
    .div0   (core_div0)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      hi         <= '0;
      lo         <= '0;
      div0       <= 1'b0;
      illegal_op <= 1'b0;
      bne_q      <= 1'b0;
    end else begin
      done       <= 1'b0;
      div0       <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          bne_q <= bne;
          if (multi) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end else begin
            done       <= 1'b1;
            result     <= base_res;
            illegal_op <= base_ill;
            if (OP == OP_MTHI) hi <= In1;
            if (OP == OP_MTLO) lo <= In1;
          end
        end
        ST_RUN: if (core_last) state <= ST_FIX;
        ST_FIX: begin
          state  <= ST_IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          result <= core_lo;
          hi     <= core_hi;
          lo     <= core_lo;
          div0   <= core_div0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - table vectors, hand sequences and randomized model checks for ula_multiciclo
// Expectations for OP 18/19 follow ULA_DIV_EN.
`timescale 1ns/1ps
module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset, start, bne;
  logic [4:0]  OP, shamt;
  logic [31:0] In1, In2;
  logic [15:0] immediate;
  logic        busy, done, Zero_flag, div0, illegal_op;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clock = ~clock;

  ula_multiciclo #(.WIDTH(32), .IMM_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .OP(OP), .In1(In1), .In2(In2),
    .shamt(shamt), .immediate(immediate), .bne(bne), .busy(busy), .done(done),
    .result(result), .Zero_flag(Zero_flag), .div0(div0), .illegal_op(illegal_op)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        bn;
    logic [31:0] res;
    logic        z;
    logic        ill;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain language arithmetic on the architectural rules.
  task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic [15:0] imm,
                          output logic [31:0] r, output int lat, output logic ill, output logic d0);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    r = 32'd0; lat = 1; ill = 1'b0; d0 = 1'b0;
    case (op)
      5'd0:  r = b << sh;
      5'd1:  r = b >> sh;
      5'd2:  r = $signed(b) >>> sh;
      5'd3:  r = b << a[4:0];
      5'd4:  r = b >> a[4:0];
      5'd5:  r = $signed(b) >>> a[4:0];
      5'd6:  r = a + b;
      5'd7:  r = a - b;
      5'd8:  r = a & b;
      5'd9:  r = a | b;
      5'd10: r = a ^ b;
      5'd11: r = ~(a | b);
      5'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd13: r = (a < b) ? 32'd1 : 32'd0;
      5'd14: r = {imm, 16'h0000};
      5'd15: r = a | {16'h0000, imm};
      5'd16: begin
        sa = $signed(a); sb = $signed(b); p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 34;
      end
      5'd17: begin
        ua = a; ub = b; p = ua * ub;
        m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = 34;
      end
`ifdef ULA_DIV_EN
      5'd18: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; d0 = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = 32'd0;
        end else begin
          m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b);
        end
        r = m_lo; lat = 34;
      end
      5'd19: begin
        if (b == 32'd0) begin
          m_lo = 32'hFFFF_FFFF; m_hi = a; d0 = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
        r = m_lo; lat = 34;
      end
`endif
      5'd20: r = m_hi;
      5'd21: r = m_lo;
      5'd22: begin m_hi = a; r = a; end
      5'd23: begin m_lo = a; r = a; end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [15:0] imm, input logic bn,
                        output logic [31:0] r, output int lat, output logic z,
                        output logic ill, output logic d0);
    @(negedge clock);
    OP = op; In1 = a; In2 = b; shamt = sh; immediate = imm; bne = bn; start = 1'b1;
    @(negedge clock);
    start = 1'b0; In1 = $urandom; In2 = $urandom; lat = 1;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
    end
    r = result; z = Zero_flag; ill = illegal_op; d0 = div0;
  endtask

  task automatic exec(input string tag, input logic [4:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] sh, input logic [15:0] imm,
                      input logic bn);
    logic [31:0] er, r;
    int elat, lat;
    logic eill, ed0, z, ill, d0, ez;
    model_op(op, a, b, sh, imm, er, elat, eill, ed0);
    run_op(op, a, b, sh, imm, bn, r, lat, z, ill, d0);
    ez = bn ? (er != 32'd0) : (er == 32'd0);
    check({tag, "_res"}, r, er);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_ill"}, ill, eill);
    check({tag, "_div0"}, d0, ed0);
    check({tag, "_zero"}, z, ez);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[25];
    logic [31:0] r, dr;
    int lat, dl, cnt_done;
    logic z, ill, d0, dil, dd0;

    vecs[0]  = '{5'd6,  32'd5,          32'd7,          5'd0,  16'h0,    1'b0, 32'd12,         1'b0, 1'b0};
    vecs[1]  = '{5'd7,  32'd9,          32'd9,          5'd0,  16'h0,    1'b1, 32'd0,          1'b0, 1'b0};
    vecs[2]  = '{5'd7,  32'd9,          32'd9,          5'd0,  16'h0,    1'b0, 32'd0,          1'b1, 1'b0};
    vecs[3]  = '{5'd0,  32'd0,          32'd1,          5'd4,  16'h0,    1'b0, 32'h10,         1'b0, 1'b0};
    vecs[4]  = '{5'd1,  32'd0,          32'h8000_0000,  5'd31, 16'h0,    1'b0, 32'd1,          1'b0, 1'b0};
    vecs[5]  = '{5'd2,  32'd0,          32'h8000_0000,  5'd4,  16'h0,    1'b0, 32'hF800_0000,  1'b0, 1'b0};
    vecs[6]  = '{5'd3,  32'd36,         32'd3,          5'd0,  16'h0,    1'b0, 32'h30,         1'b0, 1'b0};
    vecs[7]  = '{5'd4,  32'd1,          32'hF0,         5'd0,  16'h0,    1'b0, 32'h78,         1'b0, 1'b0};
    vecs[8]  = '{5'd5,  32'd8,          32'h8000_0000,  5'd0,  16'h0,    1'b0, 32'hFF80_0000,  1'b0, 1'b0};
    vecs[9]  = '{5'd6,  32'hFFFF_FFFF,  32'd1,          5'd0,  16'h0,    1'b0, 32'd0,          1'b1, 1'b0};
    vecs[10] = '{5'd7,  32'd3,          32'd5,          5'd0,  16'h0,    1'b0, 32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[11] = '{5'd8,  32'hF0F0,       32'hFF00,       5'd0,  16'h0,    1'b0, 32'hF000,       1'b0, 1'b0};
    vecs[12] = '{5'd9,  32'hF0,         32'h0F,         5'd0,  16'h0,    1'b0, 32'hFF,         1'b0, 1'b0};
    vecs[13] = '{5'd10, 32'hFF,         32'h0F,         5'd0,  16'h0,    1'b0, 32'hF0,         1'b0, 1'b0};
    vecs[14] = '{5'd11, 32'd0,          32'd0,          5'd0,  16'h0,    1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[15] = '{5'd12, 32'hFFFF_FFFF,  32'd1,          5'd0,  16'h0,    1'b0, 32'd1,          1'b0, 1'b0};
    vecs[16] = '{5'd13, 32'hFFFF_FFFF,  32'd1,          5'd0,  16'h0,    1'b0, 32'd0,          1'b1, 1'b0};
    vecs[17] = '{5'd14, 32'd0,          32'd0,          5'd0,  16'h1234, 1'b0, 32'h1234_0000,  1'b0, 1'b0};
    vecs[18] = '{5'd15, 32'h1_0000,     32'd0,          5'd0,  16'h8001, 1'b0, 32'h1_8001,     1'b0, 1'b0};
    vecs[19] = '{5'd25, 32'd5,          32'd5,          5'd0,  16'h0,    1'b0, 32'd0,          1'b1, 1'b1};
    vecs[20] = '{5'd31, 32'd5,          32'd5,          5'd0,  16'h0,    1'b1, 32'd0,          1'b0, 1'b1};
    vecs[21] = '{5'd22, 32'hDEAD_BEEF,  32'd0,          5'd0,  16'h0,    1'b0, 32'hDEAD_BEEF,  1'b0, 1'b0};
    vecs[22] = '{5'd23, 32'h1234_5678,  32'd0,          5'd0,  16'h0,    1'b0, 32'h1234_5678,  1'b0, 1'b0};
    vecs[23] = '{5'd20, 32'd0,          32'd0,          5'd0,  16'h0,    1'b0, 32'hDEAD_BEEF,  1'b0, 1'b0};
    vecs[24] = '{5'd21, 32'd0,          32'd0,          5'd0,  16'h0,    1'b0, 32'h1234_5678,  1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; bne = 1'b0; OP = 5'd0; shamt = 5'd0;
    In1 = 32'd0; In2 = 32'd0; immediate = 16'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, 32'd0);
    check("rst_zero", Zero_flag, 1'b1);
    check("rst_div0", div0, 1'b0);
    check("rst_illegal", illegal_op, 1'b0);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("rst_hi", r, 32'd0);
    run_op(5'd21, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("rst_lo", r, 32'd0);

    for (int i = 0; i < 25; i++) begin
      model_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].imm, dr, dl, dil, dd0);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].imm, vecs[i].bn, r, lat, z, ill, d0);
      check($sformatf("vec%0d_res", i), r, vecs[i].res);
      check($sformatf("vec%0d_zero", i), z, vecs[i].z);
      check($sformatf("vec%0d_ill", i), ill, vecs[i].ill);
      check($sformatf("vec%0d_lat", i), lat, 1);
      check($sformatf("vec%0d_div0", i), d0, 1'b0);
    end

    // MULT -3*7 with stray start pulses while busy and operands changed after acceptance
    model_op(5'd16, 32'hFFFF_FFFD, 32'd7, 5'd0, 16'd0, dr, dl, dil, dd0);
    @(negedge clock);
    OP = 5'd16; In1 = 32'hFFFF_FFFD; In2 = 32'd7; bne = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0; lat = 1; In1 = 32'd0; In2 = 32'd0;
    check("mul_busy", busy, 1'b1);
    repeat (3) begin @(negedge clock); lat++; end
    OP = 5'd6; In1 = 32'd1; In2 = 32'd1; start = 1'b1;
    repeat (2) begin @(negedge clock); lat++; end
    start = 1'b0;
    while (!done && lat < 200) begin @(negedge clock); lat++; end
    check("mul_lat", lat, 34);
    check("mul_lo", result, 32'hFFFF_FFEB);
    check("mul_busy_at_done", busy, 1'b0);
    OP = 5'd21; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("b2b_done", done, 1'b1);
    check("b2b_mflo", result, 32'hFFFF_FFEB);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("mul_mfhi", r, 32'hFFFF_FFFF);
    check("mul_mfhi_lat", lat, 1);

`ifdef ULA_DIV_EN
    model_op(5'd18, 32'hFFFF_FFF9, 32'd2, 5'd0, 16'd0, dr, dl, dil, dd0);
    run_op(5'd18, 32'hFFFF_FFF9, 32'd2, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("div_lo", r, 32'hFFFF_FFFD);
    check("div_lat", lat, 34);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("div_hi", r, 32'hFFFF_FFFF);
    model_op(5'd19, 32'd7, 32'd0, 5'd0, 16'd0, dr, dl, dil, dd0);
    run_op(5'd19, 32'd7, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("divu0_lo", r, 32'hFFFF_FFFF);
    check("divu0_flag", d0, 1'b1);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("divu0_hi", r, 32'd7);
    check("div0_cleared", d0, 1'b0);
    model_op(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 16'd0, dr, dl, dil, dd0);
    run_op(5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("divmin_lo", r, 32'h8000_0000);
    check("divmin_flag", d0, 1'b0);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("divmin_hi", r, 32'd0);
`else
    run_op(5'd18, 32'd7, 32'd2, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("nodiv_lat", lat, 1);
    check("nodiv_ill", ill, 1'b1);
    check("nodiv_res", r, 32'd0);
    check("nodiv_div0", d0, 1'b0);
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("nodiv_hi_kept", r, 32'hFFFF_FFFF);
`endif

    // reset in the middle of a MULTU aborts it and clears HI/LO
    @(negedge clock);
    OP = 5'd17; In1 = 32'd5; In2 = 32'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, 32'd0);
    cnt_done = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op(5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("abort_hi", r, 32'd0);
    run_op(5'd21, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0, r, lat, z, ill, d0);
    check("abort_lo", r, 32'd0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      exec($sformatf("rnd%0d_op%0d", i, op), op, pick(), pick(), 5'($urandom_range(0, 31)),
           16'($urandom), 1'($urandom_range(0, 1)));
      if (op >= 5'd16 && op <= 5'd19) begin
        exec($sformatf("rnd%0d_mfhi", i), 5'd20, 32'd0, 32'd0, 5'd0, 16'd0, 1'b0);
        exec($sformatf("rnd%0d_mflo", i), 5'd21, 32'd0, 32'd0, 5'd0, 16'd0, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
